fetch_unit: RTL

//   Instruction fetch stage sitting directly upstream of the decoder.

---
 rtl/fetch_unit.sv | 85 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one op per memory handshake and hands it to the decoder.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_unit #(
  parameter int              PC_W     = 4,
  parameter int              OP_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [OP_W-1:0] imem_rdata,
  output logic [OP_W-1:0] op_out,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [PC_W-1:0] op_pc,
  input  logic            pc_we,
`ifdef FETCH_PERF_EN
  input  logic [PC_W-1:0] pc_in,
  output logic [15:0]     fetch_cnt,
  output logic [15:0]     stall_cnt
`else
  input  logic [PC_W-1:0] pc_in
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic            accept;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign accept    = (state == VALID) && op_valid && op_ready;

  // Redirect is only honoured on the edge where the decoder consumes the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      op_out   <= '0;
      op_valid <= 1'b0;
      op_pc    <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            op_out   <= imem_rdata;
            op_pc    <= pc;
            op_valid <= 1'b1;
            state    <= VALID;
          end
        end
        VALID: begin
          if (accept) begin
            op_valid <= 1'b0;
            pc       <= pc_we ? pc_in : pc + {{(PC_W-1){1'b0}}, 1'b1};
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (accept && (fetch_cnt != 16'hFFFF))
        fetch_cnt <= fetch_cnt + 16'd1;
      if (imem_req && !imem_ack && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
